// File: rtl/partition_burst_buffer.sv
// -----------------------------------------------------------------------------
// partition_burst_buffer
//
// Sits directly downstream of one partition Gate. Buffers the Gate's tuple
// stream in a FIFO and re-emits it as bursts of BURST_LEN beats for the
// partition writer. Once the Gate reports last_processed (with no tuple
// offered), whatever is left is flushed as one final partial burst and a
// sticky done indication is raised.
//
// Handshakes (both sides): a transfer happens on a rising clk edge when
// valid and ready are both 1. A producer holding valid=1 keeps its fields
// stable until the transfer; out_valid never drops in the middle of a burst.
// in_ready and out_valid are derived from registered state only.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   in_valid / in_ready      tuple stream from the Gate
//   in_data, in_tag,
//   in_serialnum,
//   in_was_joined            tuple fields
//   in_last_processed        Gate has no more tuples (level)
//   out_valid / out_ready    beat stream to the partition writer
//   out_data, out_tag,
//   out_serialnum,
//   out_was_joined           FIFO head fields (zero while out_valid=0)
//   out_burst_first/last     first / final beat of the current burst
//   out_burst_len            beats in the current burst (zero while idle)
//   out_last_processed       sticky: all input seen and FIFO drained
//   dbg_state, dbg_count     FSM state and FIFO occupancy, for observation
// -----------------------------------------------------------------------------
module partition_burst_buffer #(
  parameter int INPUT_SIZE = 64,
  parameter int DEPTH      = 64,
  parameter int BURST_LEN  = 16,
  localparam int LW        = $clog2(BURST_LEN + 1),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INPUT_SIZE-1:0] in_data,
  input  logic [31:0]           in_tag,
  input  logic [63:0]           in_serialnum,
  input  logic                  in_was_joined,
  input  logic                  in_last_processed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INPUT_SIZE-1:0] out_data,
  output logic [31:0]           out_tag,
  output logic [63:0]           out_serialnum,
  output logic                  out_was_joined,
  output logic                  out_burst_first,
  output logic                  out_burst_last,
  output logic [LW-1:0]         out_burst_len,
  output logic                  out_last_processed,
  output logic [1:0]            dbg_state,
  output logic [CW-1:0]         dbg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = INPUT_SIZE + 32 + 64 + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);
  localparam logic [LW-1:0] BURST_L = LW'(BURST_LEN);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_BURST = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            last_seen_q;
  logic            run_q;
  logic [LW-1:0]   beats_left_q, beats_left_d;
  logic [LW-1:0]   burst_len_q, burst_len_d;
  logic            first_q, first_d;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic            push, pop;
  logic            bursting;

  // run_q keeps in_ready low while reset is asserted and rises on the first
  // clock edge after release, so in_ready stays a purely registered signal.
  assign bursting = (state_q == S_BURST) || (state_q == S_FLUSH);
  assign in_ready = run_q && (count_q != DEPTH_C) && (state_q != S_DONE);
  assign out_valid = bursting;
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset needed; occupancy is tracked by count_q)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_data, in_tag, in_serialnum, in_was_joined};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // last_processed only counts while no tuple is being offered
      if (!in_valid && in_last_processed) last_seen_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_FILL;
      beats_left_q <= '0;
      burst_len_q  <= '0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      burst_len_q  <= burst_len_d;
      first_q      <= first_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst FSM: next state. A full burst always wins over a flush, and a burst
  // in progress runs to completion before anything else is considered.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    burst_len_d  = burst_len_q;
    first_d      = first_q;
    case (state_q)
      S_FILL: begin
        if (count_q >= BURST_C) begin
          state_d      = S_BURST;
          beats_left_d = BURST_L;
          burst_len_d  = BURST_L;
          first_d      = 1'b1;
        end else if (last_seen_q && (count_q != '0)) begin
          // count_q < BURST_LEN here, so it fits in LW bits
          state_d      = S_FLUSH;
          beats_left_d = LW'(count_q);
          burst_len_d  = LW'(count_q);
          first_d      = 1'b1;
        end else if (last_seen_q) begin
          state_d = S_DONE;
        end
      end
      S_BURST, S_FLUSH: begin
        if (pop) begin
          first_d      = 1'b0;
          beats_left_d = beats_left_q - LW'(1);
          if (beats_left_q == LW'(1)) state_d = S_FILL;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: beat fields are forced to zero outside a burst so every output
  // reads 0 during and right after reset.
  // ---------------------------------------------------------------------------
  assign head = mem[rd_ptr_q];

  assign out_data           = bursting ? head[EW-1 -: INPUT_SIZE] : '0;
  assign out_tag            = bursting ? head[96:65] : '0;
  assign out_serialnum      = bursting ? head[64:1]  : '0;
  assign out_was_joined     = bursting && head[0];
  assign out_burst_first    = bursting && first_q;
  assign out_burst_last     = bursting && (beats_left_q == LW'(1));
  assign out_burst_len      = bursting ? burst_len_q : '0;
  assign out_last_processed = (state_q == S_DONE);

  assign dbg_state = state_q;
  assign dbg_count = count_q;

endmodule

// File: tb/tb_partition_burst_buffer.sv
// -----------------------------------------------------------------------------
// tb_partition_burst_buffer
//
// Directed and randomized stimulus for partition_burst_buffer with
// BURST_LEN=4, DEPTH=64. A queue of pushed tuples is the reference: every
// beat must match the queue head; burst framing is derived from the queue
// occupancy when a burst starts (full burst if at least BURST_LEN tuples are
// waiting, otherwise a flush of everything left).
// -----------------------------------------------------------------------------
module tb_partition_burst_buffer;

  localparam int INPUT_SIZE = 64;
  localparam int DEPTH      = 64;
  localparam int BL         = 4;
  localparam int LW         = $clog2(BL + 1);
  localparam int CW         = $clog2(DEPTH + 1);
  localparam int W          = INPUT_SIZE + 32 + 64 + 1;

  // clock / reset
  logic clk;
  logic resetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic                  in_valid, in_ready;
  logic [INPUT_SIZE-1:0] in_data;
  logic [31:0]           in_tag;
  logic [63:0]           in_serialnum;
  logic                  in_was_joined, in_last_processed;
  logic                  out_valid, out_ready;
  logic [INPUT_SIZE-1:0] out_data;
  logic [31:0]           out_tag;
  logic [63:0]           out_serialnum;
  logic                  out_was_joined, out_burst_first, out_burst_last;
  logic [LW-1:0]         out_burst_len;
  logic                  out_last_processed;
  logic [1:0]            dbg_state;
  logic [CW-1:0]         dbg_count;

  partition_burst_buffer #(
    .INPUT_SIZE(INPUT_SIZE),
    .DEPTH(DEPTH),
    .BURST_LEN(BL)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_tag(in_tag),
    .in_serialnum(in_serialnum),
    .in_was_joined(in_was_joined),
    .in_last_processed(in_last_processed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag),
    .out_serialnum(out_serialnum),
    .out_was_joined(out_was_joined),
    .out_burst_first(out_burst_first),
    .out_burst_last(out_burst_last),
    .out_burst_len(out_burst_len),
    .out_last_processed(out_last_processed),
    .dbg_state(dbg_state),
    .dbg_count(dbg_count)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           done_lens[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           beat_idx = 0;
  int           cur_len = 0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_obs = '0;
  bit           lp_phase = 1'b0;
  logic [63:0]  next_serial = 64'd0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle, called just after a falling edge: check outputs against
  // the model, drive the inputs for the next rising edge, update the model.
  task automatic tick(input bit iv, input bit orr, input bit ilp);
    logic [W-1:0] obs;
    int           exp_len;
    bit           push, pop;
    obs = {out_data, out_tag, out_serialnum, out_was_joined};
    check("count", W'(dbg_count), W'(exp_q.size()));
    if (!lp_phase) check("in_ready", W'(in_ready), W'(exp_q.size() != DEPTH));
    if (prev_stall) begin
      check("stall_valid", W'(out_valid), W'(1));
      check("stall_fields", obs, prev_obs);
    end
    if (out_valid) begin
      if (beat_idx == 0) begin
        exp_len = (exp_q.size() >= BL) ? BL : exp_q.size();
        cur_len = exp_len;
        check("burst_len", W'(out_burst_len), W'(exp_len));
        check("first", W'(out_burst_first), W'(1));
      end else begin
        check("first_mid", W'(out_burst_first), W'(0));
        check("len_hold", W'(out_burst_len), W'(cur_len));
      end
      check("last", W'(out_burst_last), W'(beat_idx == cur_len - 1));
      check("head_avail", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) check("beat", obs, exp_q[0]);
    end else begin
      check("no_drop", W'(beat_idx), W'(0));
    end

    in_valid          = iv;
    out_ready         = orr;
    in_last_processed = ilp;
    if (iv) begin
      in_data       = {$urandom, $urandom};
      in_tag        = $urandom;
      in_serialnum  = next_serial;
      in_was_joined = 1'($urandom);
    end
    push = iv && in_ready;
    pop  = out_valid && orr;
    if (pop && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      beat_idx++;
      if (beat_idx >= cur_len) begin
        done_lens.push_back(cur_len);
        beat_idx = 0;
      end
    end
    if (push) begin
      exp_q.push_back({in_data, in_tag, in_serialnum, in_was_joined});
      next_serial++;
    end
    prev_stall = out_valid && !orr;
    prev_obs   = obs;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, W'(out_valid), W'(0));
    check({tag, "_in_ready"}, W'(in_ready), W'(0));
    check({tag, "_fields"}, {out_data, out_tag, out_serialnum, out_was_joined}, W'(0));
    check({tag, "_framing"}, W'({out_burst_first, out_burst_last, out_burst_len}), W'(0));
    check({tag, "_lp"}, W'(out_last_processed), W'(0));
    check({tag, "_state"}, W'(dbg_state), W'(0));
    check({tag, "_count"}, W'(dbg_count), W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] lat_exp;
    bit         seen;

    // ---- reset ----
    resetn = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_last_processed = 1'b0;
    in_data = '0; in_tag = '0; in_serialnum = '0; in_was_joined = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_ready", W'(in_ready), W'(1));

    // ---- first burst latency: beats on edges 2..5 after the 4th push ----
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    lat_exp = 6'b011110;
    for (int k = 0; k < 6; k++) begin
      check("latency_valid", W'(out_valid), W'(lat_exp[k]));
      tick(1'b0, 1'b1, 1'b0);
    end

    // ---- fill to DEPTH while the writer stalls ----
    for (int i = 0; i < DEPTH + 6; i++) tick(1'b1, 1'b0, 1'b0);
    check("full_count", W'(dbg_count), W'(DEPTH));
    check("full_ready", W'(in_ready), W'(0));
    tick(1'b0, 1'b1, 1'b0);
    check("ready_after_pop", W'(in_ready), W'(1));
    // drain with out_ready toggling every cycle
    for (int i = 0; i < 160; i++) tick(1'b0, i[0], 1'b0);

    // ---- random traffic ----
    for (int i = 0; i < 2000; i++)
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);
    // steady push+pop around count=BURST_LEN across many pointer wraps
    for (int i = 0; i < 200; i++) tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 1'b0);

    // ---- reset in the middle of a burst ----
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick(1'b0, 1'b0, 1'b0);
    end
    check("burst_started", W'(out_valid), W'(1));
    tick(1'b0, 1'b1, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 resetn = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_q.delete();
    beat_idx = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rel_ready", W'(in_ready), W'(1));
    check("rel_state", W'(dbg_state), W'(0));
    check("rel_count", W'(dbg_count), W'(0));

    // ---- 6 tuples, then last_processed: burst of 4, flush of 2, done ----
    done_lens.delete();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0);
    lp_phase = 1'b1;
    for (int i = 0; i < 40 && !out_last_processed; i++) tick(1'b0, 1'b1, 1'b1);
    check("done_reached", W'(out_last_processed), W'(1));
    check("burst_count", W'(done_lens.size()), W'(2));
    if (done_lens.size() == 2) begin
      check("full_burst_len", W'(done_lens[0]), W'(BL));
      check("flush_len", W'(done_lens[1]), W'(2));
    end
    check("drained", W'(exp_q.size()), W'(0));
    for (int i = 0; i < 3; i++) begin
      check("done_ready", W'(in_ready), W'(0));
      check("done_valid", W'(out_valid), W'(0));
      check("done_sticky", W'(out_last_processed), W'(1));
      tick(1'b1, 1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
